saturn_bus_sequencer: RTL
=========================

SATURN_BUS_SEQUENCER -- requirements
Module: saturn_bus_sequencer

Interface
REQ-001 SHALL have port i_clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have port i_reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port i_clk_en  input  1  advance enable; no state changes when low.
REQ-004 SHALL have port i_phases  input  4  one-hot bus phase, bit n high in phase n.
REQ-005 SHALL have port i_program_data  input  5  bus program entry at o_program_address; bit4=1 command, bit4=0 data nibble.
REQ-006 SHALL have port i_program_end  input  5  producer write pointer; entries [o_program_address, i_program_end) are pending.
REQ-007 SHALL have port o_program_address  output  5  consumer read pointer.
REQ-008 SHALL have port i_no_read  input  1  suppresses idle read strobes.
REQ-009 SHALL have ports o_bus_strobe (1), o_bus_cmd_data (1), o_bus_data (4)  output  bus drive; o_bus_cmd_data high marks a command nibble.
REQ-010 SHALL have port i_bus_data  input  4  nibble returned by memory.
REQ-011 SHALL have ports o_nibble (4), o_nibble_valid (1)  output  captured read data and one-clk_en-cycle valid pulse.
REQ-012 SHALL have ports o_bus_busy (1), o_error (1)  output  busy and sticky protocol error.
REQ-013 SHALL have port o_bus_address  output  20  shadow bus address (see Configuration).

Function
REQ-014 SHALL implement states IDLE, CMD, ADDR, READ, WRITE, ERROR; one program entry consumed per bus cycle, only on i_clk_en && i_phases[1].
REQ-015 SHALL, when pending (o_program_address != i_program_end) and entry bit4=1, drive it with o_bus_cmd_data=1, o_bus_strobe=1 for that clk_en cycle, increment pointer, enter CMD.
REQ-016 SHALL after LOAD_PC/LOAD_DP enter ADDR and require exactly 5 data entries, low nibble first; after PC_READ/DP_READ enter READ; after DP_WRITE enter WRITE; after other commands return to IDLE.
REQ-017 SHALL in ADDR/WRITE drive each data entry with o_bus_cmd_data=0, o_bus_strobe=1; ADDR returns to IDLE after the 5th nibble.
REQ-018 SHALL in READ with no pending entry and i_no_read low strobe a read at phase 1, capture i_bus_data on i_clk_en && i_phases[2], pulse o_nibble_valid that cycle.
REQ-019 SHALL leave READ/WRITE when a command entry becomes pending; a data entry pending in READ SHALL set error.
REQ-020 SHALL set o_error and enter ERROR on command entry in ADDR before 5 nibbles, or data entry in IDLE; ERROR consumes nothing until reset.
REQ-021 SHALL pointer wrap 31->0; empty is pointer equality; overrun avoidance is the producer's duty.
REQ-022 SHALL hold o_bus_busy high when entries are pending or state is CMD/ADDR; low in IDLE/READ/WRITE with nothing pending.
REQ-023 SHALL give entry-to-strobe latency of at most one bus cycle (4 clk_en cycles).
REQ-024 SHALL, if a new entry and a read coincide at phase 1, serve the entry; no read strobe that cycle.

Reset
REQ-025 SHALL on i_reset_n low immediately set: state IDLE, o_program_address 0, o_bus_strobe 0, o_bus_cmd_data 0, o_bus_data 0, o_nibble 0, o_nibble_valid 0, o_bus_busy 0, o_error 0, o_bus_address 0, nibble counter 0.
REQ-026 SHALL abandon any mid-transfer sequence on reset with no further strobes.

Configuration
REQ-027 SHALL with SATURN_BUS_ADDR_TRACK_EN defined assemble o_bus_address from ADDR nibbles and increment it modulo 2^20 after each read or write nibble.
REQ-028 SHALL without SATURN_BUS_ADDR_TRACK_EN tie o_bus_address to 0 and instantiate no tracking logic.

Structure
REQ-029 SHALL take BUSCMD codes, state encoding and address-nibble count (5) from the shared bus definitions package/include.
REQ-030 SHALL place address tracking in sub-module saturn_bus_addr_tracker, instantiated only under the macro.

Verification
REQ-031 SHALL cover: LOAD_PC + nibbles 5,4,3,2,1 -> six strobes, cmd_data 1 then 0x5, o_bus_address 0x12345 (macro on), busy falls after 5th.
REQ-032 SHALL cover: PC_READ, i_bus_data 0xA then 0xB -> o_nibble_valid pulses with 0xA, 0xB; address increments 0x12345->0x12347.
REQ-033 SHALL cover: LOAD_DP + 3 nibbles then command -> o_error=1, pointer frozen, no strobes until reset.
REQ-034 SHALL cover: pointer at 30, producer writes 3 entries to 30,31,0 -> all consumed, pointer ends at 1.
REQ-035 SHALL cover: i_reset_n low during ADDR nibble 3 -> all outputs at reset values same cycle; fresh LOAD_PC afterwards completes normally.
REQ-036 SHALL cover: READ with i_no_read=1 for 8 bus cycles -> zero strobes, zero valid pulses.

Source files
------------

// File: rtl/saturn_bus_sequencer_pkg.sv
// Shared Saturn bus definitions: widths, BUSCMD codes, sequencer states and program entry layout.
package saturn_bus_sequencer_pkg;

    localparam int unsigned NIB_W        = 4;
    localparam int unsigned ENTRY_W      = NIB_W + 1;
    localparam int unsigned PTR_W        = 5;
    localparam int unsigned PHASE_W      = 4;
    localparam int unsigned ADDR_W       = 20;
    localparam int unsigned ADDR_NIBBLES = 5;
    localparam int unsigned NCNT_W       = 3;

    localparam logic [PHASE_W-1:0] PHASE_1 = 4'b0010;
    localparam logic [PHASE_W-1:0] PHASE_2 = 4'b0100;

    localparam logic [NIB_W-1:0] BUSCMD_PC_READ     = 4'h0;
    localparam logic [NIB_W-1:0] BUSCMD_DP_WRITE    = 4'h1;
    localparam logic [NIB_W-1:0] BUSCMD_DP_READ     = 4'h2;
    localparam logic [NIB_W-1:0] BUSCMD_LOAD_PC     = 4'h4;
    localparam logic [NIB_W-1:0] BUSCMD_LOAD_DP     = 4'h5;
    localparam logic [NIB_W-1:0] BUSCMD_CONFIGURE   = 4'h6;
    localparam logic [NIB_W-1:0] BUSCMD_UNCONFIGURE = 4'h7;
    localparam logic [NIB_W-1:0] BUSCMD_POLL        = 4'h8;
    localparam logic [NIB_W-1:0] BUSCMD_RESET       = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    // One bus program slot: cmd=1 marks a command nibble, cmd=0 a data nibble.
    typedef struct packed {
        logic             cmd;
        logic [NIB_W-1:0] nib;
    } prog_entry_t;

endpackage

// File: rtl/saturn_bus_addr_tracker.sv
// Shadow bus address: assembled from LOAD address nibbles, bumped after each read/write nibble.
module saturn_bus_addr_tracker
    import saturn_bus_sequencer_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_load,
    input  logic [NCNT_W-1:0] i_load_idx,
    input  logic [NIB_W-1:0]  i_load_nibble,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_address
);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_address <= '0;
        end else if (i_load) begin
            for (int unsigned k = 0; k < ADDR_NIBBLES; k++) begin
                if (i_load_idx == NCNT_W'(k)) begin
                    o_address[k*NIB_W +: NIB_W] <= i_load_nibble;
                end
            end
        end else if (i_inc) begin
            o_address <= o_address + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/saturn_bus_sequencer.sv
// Saturn bus sequencer: consumes a 32-entry command/data program and drives the nibble bus.
// Optional shadow address tracking is enabled by defining SATURN_BUS_ADDR_TRACK_EN.
module saturn_bus_sequencer
    import saturn_bus_sequencer_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_clk_en,
    input  logic [PHASE_W-1:0] i_phases,
    input  logic [ENTRY_W-1:0] i_program_data,
    input  logic [PTR_W-1:0]   i_program_end,
    output logic [PTR_W-1:0]   o_program_address,
    input  logic               i_no_read,
    output logic               o_bus_strobe,
    output logic               o_bus_cmd_data,
    output logic [NIB_W-1:0]   o_bus_data,
    input  logic [NIB_W-1:0]   i_bus_data,
    output logic [NIB_W-1:0]   o_nibble,
    output logic               o_nibble_valid,
    output logic               o_bus_busy,
    output logic               o_error,
    output logic [ADDR_W-1:0]  o_bus_address
);

    state_t            state_q, state_d;
    logic [NIB_W-1:0]  cmd_q, cmd_d;
    logic [NCNT_W-1:0] ncnt_q, ncnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic [PTR_W-1:0]  ptr_d;
    logic              strobe_d, cmd_data_d, valid_d, busy_d, error_d;
    logic [NIB_W-1:0]  bus_data_d, nibble_d;
    logic              consume, err_hit;
    logic              pending, phase1, phase2;
    prog_entry_t       entry;

    assign entry   = prog_entry_t'(i_program_data);
    assign pending = (o_program_address != i_program_end);
    assign phase1  = (i_phases == PHASE_1);
    assign phase2  = (i_phases == PHASE_2);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q           <= ST_IDLE;
            cmd_q             <= '0;
            ncnt_q            <= '0;
            rd_pend_q         <= 1'b0;
            o_program_address <= '0;
            o_bus_strobe      <= 1'b0;
            o_bus_cmd_data    <= 1'b0;
            o_bus_data        <= '0;
            o_nibble          <= '0;
            o_nibble_valid    <= 1'b0;
            o_bus_busy        <= 1'b0;
            o_error           <= 1'b0;
        end else begin
            state_q           <= state_d;
            cmd_q             <= cmd_d;
            ncnt_q            <= ncnt_d;
            rd_pend_q         <= rd_pend_d;
            o_program_address <= ptr_d;
            o_bus_strobe      <= strobe_d;
            o_bus_cmd_data    <= cmd_data_d;
            o_bus_data        <= bus_data_d;
            o_nibble          <= nibble_d;
            o_nibble_valid    <= valid_d;
            o_bus_busy        <= busy_d;
            o_error           <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        ncnt_d     = ncnt_q;
        rd_pend_d  = rd_pend_q;
        ptr_d      = o_program_address;
        strobe_d   = o_bus_strobe;
        cmd_data_d = o_bus_cmd_data;
        bus_data_d = o_bus_data;
        nibble_d   = o_nibble;
        valid_d    = o_nibble_valid;
        busy_d     = o_bus_busy;
        error_d    = o_error;
        consume    = 1'b0;
        err_hit    = 1'b0;

        if (i_clk_en) begin
            strobe_d = 1'b0;
            valid_d  = 1'b0;

            // CMD is a one-clk_en decode step of the command just issued.
            if (state_q == ST_CMD) begin
                ncnt_d = '0;
                case (cmd_q)
                    BUSCMD_LOAD_PC, BUSCMD_LOAD_DP: state_d = ST_ADDR;
                    BUSCMD_PC_READ, BUSCMD_DP_READ: state_d = ST_READ;
                    BUSCMD_DP_WRITE:                state_d = ST_WRITE;
                    default:                        state_d = ST_IDLE;
                endcase
            end

            if (phase2 && rd_pend_q) begin
                nibble_d  = i_bus_data;
                valid_d   = 1'b1;
                rd_pend_d = 1'b0;
            end

            if (phase1 && state_q != ST_ERROR && state_q != ST_CMD) begin
                if (pending) begin
                    if (entry.cmd) begin
                        if (state_q == ST_ADDR) begin
                            err_hit = 1'b1;
                        end else begin
                            consume = 1'b1;
                            cmd_d   = entry.nib;
                            state_d = ST_CMD;
                        end
                    end else if (state_q == ST_ADDR) begin
                        consume = 1'b1;
                        ncnt_d  = ncnt_q + NCNT_W'(1);
                        if (ncnt_q == NCNT_W'(ADDR_NIBBLES - 1)) begin
                            state_d = ST_IDLE;
                        end
                    end else if (state_q == ST_WRITE) begin
                        consume = 1'b1;
                    end else begin
                        err_hit = 1'b1;
                    end
                end else if (state_q == ST_READ && !i_no_read) begin
                    strobe_d   = 1'b1;
                    cmd_data_d = 1'b0;
                    bus_data_d = '0;
                    rd_pend_d  = 1'b1;
                end
            end

            if (consume) begin
                strobe_d   = 1'b1;
                cmd_data_d = entry.cmd;
                bus_data_d = entry.nib;
                ptr_d      = o_program_address + PTR_W'(1);
            end

            // Offending entry stays unconsumed so the pointer freezes on it.
            if (err_hit) begin
                state_d = ST_ERROR;
                error_d = 1'b1;
            end

            busy_d = (ptr_d != i_program_end) || (state_d == ST_CMD) || (state_d == ST_ADDR);
        end
    end

`ifdef SATURN_BUS_ADDR_TRACK_EN
    logic addr_load, addr_inc;

    assign addr_load = consume && (state_q == ST_ADDR);
    assign addr_inc  = (i_clk_en && phase2 && rd_pend_q)
                     || (consume && !entry.cmd && (state_q == ST_WRITE));

    saturn_bus_addr_tracker u_addr_tracker (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_load        (addr_load),
        .i_load_idx    (ncnt_q),
        .i_load_nibble (entry.nib),
        .i_inc         (addr_inc),
        .o_address     (o_bus_address)
    );
`else
    assign o_bus_address = '0;
`endif

endmodule
